// File: rtl/pim_ld_pkg.sv
// Shared types for the PIM operand loader: FSM state, FIFO entry layout, index width helper.
package pim_ld_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam int PIM_N = 10;

  typedef struct packed {
    logic             last;
    logic [PIM_N-1:0] data;
  } fifo_entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pim_ld_fifo.sv
// Synchronous operand FIFO; pointers wrap modulo DEPTH (power of two).
// Push is ignored when full and pop when empty, regardless of the other side.
module pim_ld_fifo
  import pim_ld_pkg::*;
#(
  parameter int W     = $bits(fifo_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wr_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rd_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

endmodule

// File: rtl/pim_operand_loader.sv
// Buffers operand words and writes them in order into the PIM register bank with a one-hot strobe.
// Optional even-parity screening of input words is enabled with the PIM_LD_PARITY_EN macro.
module pim_operand_loader
  import pim_ld_pkg::*;
#(
  parameter int N          = 10,
  parameter int NUM_REGS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_data,
  input  logic                        in_last,
  input  logic                        pim_busy,
  output logic [NUM_REGS-1:0]         pim_load,
  output logic [N-1:0]                pim_d,
  output logic                        frame_done,
  output logic [$clog2(NUM_REGS)-1:0] load_idx
`ifdef PIM_LD_PARITY_EN
  ,
  input  logic                        in_par,
  output logic                        par_err
`endif
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REGS-1:0] r_load;
  logic [N-1:0]        r_d;
  logic                r_fd;
  logic [IW-1:0]       r_idx;
  logic                w_push;
  logic                w_issue;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [N:0]          w_head;
  logic                w_wrap;
  logic                w_last_out;

  assign in_ready = !w_full;

`ifdef PIM_LD_PARITY_EN
  logic r_par_err;
  logic w_par_ok;
  // Bad-parity words still complete the handshake; they are just never buffered.
  assign w_par_ok = ((^in_data) == in_par);
  assign w_push   = in_valid && in_ready && w_par_ok;
  assign par_err  = r_par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_par_err <= 1'b0;
    else if (in_valid && in_ready && !w_par_ok) r_par_err <= 1'b1;
  end
`else
  assign w_push = in_valid && in_ready;
`endif

  pim_ld_fifo #(.W(N + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_wr_dat ({in_last, in_data}),
    .i_pop    (w_issue),
    .o_rd_dat (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Pop is not gated on ISSUE so the first word skips the IDLE->ISSUE cycle.
  assign w_issue    = !w_empty && !pim_busy;
  assign w_wrap     = w_head[N] || (r_idx == IW'(NUM_REGS - 1));
  assign w_last_out = w_empty || (w_count == CW'(1) && w_issue && !w_push);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = pim_busy ? HOLD : ISSUE;
      ISSUE:   if (w_last_out) w_state_nxt = IDLE;
               else if (pim_busy) w_state_nxt = HOLD;
      HOLD:    if (w_empty) w_state_nxt = IDLE;
               else if (!pim_busy) w_state_nxt = ISSUE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_load  <= '0;
      r_d     <= '0;
      r_fd    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_load <= {{(NUM_REGS-1){1'b0}}, 1'b1} << r_idx;
        r_d    <= w_head[N-1:0];
        r_fd   <= w_wrap;
        r_idx  <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_load <= '0;
        r_fd   <= 1'b0;
      end
    end
  end

  assign pim_load   = r_load;
  assign pim_d      = r_d;
  assign frame_done = r_fd;
  assign load_idx   = r_idx;

endmodule

// File: tb/tb_pim_operand_loader.sv
// Randomized bench for pim_operand_loader against a frame/index model of the register bank.
module tb_pim_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       pim_busy = 1'b0;
  logic [7:0] pim_load;
  logic [9:0] pim_d;
  logic       frame_done;
  logic [2:0] load_idx;
`ifdef PIM_LD_PARITY_EN
  logic       in_par = 1'b0;
  logic       par_err;
`endif

  pim_operand_loader #(.N(10), .NUM_REGS(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .pim_busy   (pim_busy),
    .pim_load   (pim_load),
    .pim_d      (pim_d),
    .frame_done (frame_done),
    .load_idx   (load_idx)
`ifdef PIM_LD_PARITY_EN
    ,
    .in_par     (in_par),
    .par_err    (par_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] load;
    logic [9:0] d;
    logic       fd;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  m_idx = 0;
  int  cyc = 0;
  int  inv_err = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!$onehot0(pim_load) || (frame_done && pim_load == 8'h00)) inv_err++;
    if (pim_load != 8'h00) obs_q.push_back('{pim_load, pim_d, frame_done, cyc});
  end

  // Bank model: each accepted word lands in the next register; a frame ends on last or register 7.
  task automatic model_accept(input logic [9:0] d, input logic l);
    ev_t e;
    e.load = 8'd1 << m_idx;
    e.d    = d;
    e.fd   = l || (m_idx == 7);
    e.cyc  = 0;
    exp_q.push_back(e);
    m_idx  = e.fd ? 0 : m_idx + 1;
  endtask

  task automatic step(input logic v, input logic [9:0] d, input logic l, input logic b,
                      input logic par_bad);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    pim_busy = b;
`ifdef PIM_LD_PARITY_EN
    in_par = (^d) ^ par_bad;
    if (v && in_ready && !par_bad) model_accept(d, l);
`else
    if (v && in_ready) model_accept(d, l);
`endif
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    pim_busy = 1'b0;
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (pim_load !== 8'h00) $display("FAIL rst_load: got %h want 00", pim_load); else n_pass++;
    n_chk++; if (pim_d !== 10'h000) $display("FAIL rst_d: got %h want 000", pim_d); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b want 0", frame_done); else n_pass++;
    n_chk++; if (load_idx !== 3'd0) $display("FAIL rst_idx: got %0d want 0", load_idx); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_rdy: got %b want 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    step(1, 10'h011, 0, 0, 0);
    step(1, 10'h012, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 10'(i + 20), 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    obs_q.delete();
    m_idx = 0;
    @(negedge clk);
    n_chk++; if (pim_load !== 8'h00) $display("FAIL midrst_load: got %h want 00", pim_load); else n_pass++;
    n_chk++; if (load_idx !== 3'd0) $display("FAIL midrst_idx: got %0d want 0", load_idx); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL midrst_rdy: got %b want 1", in_ready); else n_pass++;
    in_valid = 1'b0;
    pim_busy = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) $display("FAIL midrst_drop: got %0d strobes want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_stream8();
    int c0;
    c0 = cyc + 1;
    for (int i = 1; i <= 8; i++) begin
      step(1, 10'(i), 0, 0, 0);
      if (i == 1) c0 = cyc;
    end
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL s8_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (obs_q[k].load !== exp_q[k].load || obs_q[k].d !== exp_q[k].d || obs_q[k].fd !== exp_q[k].fd)
        $display("FAIL s8_ev%0d: got %h/%h/%b want %h/%h/%b", k, obs_q[k].load, obs_q[k].d, obs_q[k].fd,
                 exp_q[k].load, exp_q[k].d, exp_q[k].fd);
      else n_pass++;
      n_chk++; if (obs_q[k].cyc != c0 + 2 + k) $display("FAIL s8_cyc%0d: got %0d want %0d", k, obs_q[k].cyc, c0 + 2 + k); else n_pass++;
    end
    n_chk++; if (load_idx !== 3'(m_idx)) $display("FAIL s8_idx: got %0d want %0d", load_idx, m_idx); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 4; i++) step(1, 10'($urandom_range(0, 1023)), (i == 2), 0, 0);
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL sf_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (obs_q[k].load !== exp_q[k].load || obs_q[k].d !== exp_q[k].d || obs_q[k].fd !== exp_q[k].fd)
        $display("FAIL sf_ev%0d: got %h/%h/%b want %h/%h/%b", k, obs_q[k].load, obs_q[k].d, obs_q[k].fd,
                 exp_q[k].load, exp_q[k].d, exp_q[k].fd);
      else n_pass++;
    end
    n_chk++; if (load_idx !== 3'(m_idx)) $display("FAIL sf_idx: got %0d want %0d", load_idx, m_idx); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy();
    for (int i = 0; i < 6; i++) step(1, 10'($urandom_range(0, 1023)), 0, 1, 0);
    @(posedge clk); #1;
    n_chk++; if (exp_q.size() != 4) $display("FAIL busy_acc: got %0d want 4", exp_q.size()); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL busy_rdy: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (obs_q.size() != 0) $display("FAIL busy_nostrobe: got %0d want 0", obs_q.size()); else n_pass++;
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL busy_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (obs_q[k].load !== exp_q[k].load || obs_q[k].d !== exp_q[k].d || obs_q[k].fd !== exp_q[k].fd)
        $display("FAIL busy_ev%0d: got %h/%h/%b want %h/%h/%b", k, obs_q[k].load, obs_q[k].d, obs_q[k].fd,
                 exp_q[k].load, exp_q[k].d, exp_q[k].fd);
      else n_pass++;
      n_chk++; if (obs_q[k].cyc != obs_q[0].cyc + k) $display("FAIL busy_b2b%0d: got %0d want %0d", k, obs_q[k].cyc, obs_q[0].cyc + k); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 2; i++) step(1, 10'($urandom_range(0, 1023)), 0, 1, 0);
    @(posedge clk); #1;
    n_chk++; if (dut.w_count !== 3'd2) $display("FAIL pp_fill: got %0d want 2", dut.w_count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1, 10'($urandom_range(0, 1023)), 0, 0, 0);
      @(posedge clk); #1;
      n_chk++; if (dut.w_count !== 3'd2) $display("FAIL pp_keep%0d: got %0d want 2", i, dut.w_count); else n_pass++;
    end
    for (int i = 0; i < 2; i++) step(1, 10'($urandom_range(0, 1023)), 0, 1, 0);
    @(posedge clk); #1;
    n_chk++; if (dut.w_count !== 3'd4 || in_ready !== 1'b0) $display("FAIL pp_full: got %0d/%b want 4/0", dut.w_count, in_ready); else n_pass++;
    step(1, 10'h3ff, 0, 0, 0);
    @(posedge clk); #1;
    n_chk++; if (dut.w_count !== 3'd3) $display("FAIL pp_fullpop: got %0d want 3", dut.w_count); else n_pass++;
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL pp_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (obs_q[k].load !== exp_q[k].load || obs_q[k].d !== exp_q[k].d || obs_q[k].fd !== exp_q[k].fd)
        $display("FAIL pp_ev%0d: got %h/%h/%b want %h/%h/%b", k, obs_q[k].load, obs_q[k].d, obs_q[k].fd,
                 exp_q[k].load, exp_q[k].d, exp_q[k].fd);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 10'($urandom_range(0, 1023)), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 3, 0);
    drain();
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_chk++;
      if (obs_q[k].load !== exp_q[k].load || obs_q[k].d !== exp_q[k].d || obs_q[k].fd !== exp_q[k].fd)
        $display("FAIL rnd_ev%0d: got %h/%h/%b want %h/%h/%b", k, obs_q[k].load, obs_q[k].d, obs_q[k].fd,
                 exp_q[k].load, exp_q[k].d, exp_q[k].fd);
      else n_pass++;
    end
    n_chk++; if (load_idx !== 3'(m_idx)) $display("FAIL rnd_idx: got %0d want %0d", load_idx, m_idx); else n_pass++;
    n_chk++; if (inv_err != 0) $display("FAIL onehot_inv: got %0d violations want 0", inv_err); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef PIM_LD_PARITY_EN
  task automatic test_parity();
    int idx0;
    idx0 = m_idx;
    n_chk++; if (par_err !== 1'b0) $display("FAIL par_init: got %b want 0", par_err); else n_pass++;
    step(1, 10'h003, 1, 0, 1);
    @(posedge clk); #1;
    n_chk++; if (par_err !== 1'b1) $display("FAIL par_set: got %b want 1", par_err); else n_pass++;
    n_chk++; if (load_idx !== 3'(idx0)) $display("FAIL par_idx: got %0d want %0d", load_idx, idx0); else n_pass++;
    step(1, 10'h005, 0, 0, 0);
    drain();
    n_chk++; if (par_err !== 1'b1) $display("FAIL par_sticky: got %b want 1", par_err); else n_pass++;
    n_chk++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL par_cnt: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() == 1 && exp_q.size() == 1) begin
      n_chk++;
      if (obs_q[0].load !== exp_q[0].load || obs_q[0].d !== exp_q[0].d || obs_q[0].fd !== exp_q[0].fd)
        $display("FAIL par_ev: got %h/%h/%b want %h/%h/%b", obs_q[0].load, obs_q[0].d, obs_q[0].fd,
                 exp_q[0].load, exp_q[0].d, exp_q[0].fd);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_stream8();
    test_short_frame();
    test_busy();
    test_push_pop();
`ifdef PIM_LD_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
